// File: rtl/ws2812_decoder_if.sv
// Pixel output bundle of the WS2812 decoder: decoded GRB pixel, its in-frame
// address and the per-frame status strobes.
interface ws2812_decoder_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [7:0]            pixel_g_o;
  logic [7:0]            pixel_r_o;
  logic [7:0]            pixel_b_o;
  logic [ADDR_WIDTH-1:0] led_address_o;
  logic                  pixel_valid_o;
  logic                  frame_done_o;
  logic                  bit_error_o;
  logic                  overflow_o;

  modport master (
    output pixel_g_o, pixel_r_o, pixel_b_o, led_address_o,
    output pixel_valid_o, frame_done_o, bit_error_o, overflow_o
  );

  modport slave (
    input pixel_g_o, pixel_r_o, pixel_b_o, led_address_o,
    input pixel_valid_o, frame_done_o, bit_error_o, overflow_o
  );
endinterface

// File: rtl/ws2812_decoder.sv
// WS2812 stream decoder: recovers GRB pixels and their in-frame address from
// the raw strip line. Define WS2812_DECODER_FORWARD_EN to build the repeat
// path that forwards pixels 1..N on led_data_o; otherwise led_data_o is 0.
module ws2812_decoder #(
  parameter int unsigned T_THRESHOLD = 26,
  parameter int unsigned T_HIGH_MAX  = 75,
  parameter int unsigned T_RESET     = 2500,
  parameter int unsigned LED_COUNT   = 320,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              led_data_i,
  output logic              led_data_o,
  ws2812_decoder_if.master  pix
);

  localparam int unsigned LW = $clog2(T_RESET + 1);
  localparam int unsigned HW = $clog2(T_HIGH_MAX + 2);

  typedef enum logic [1:0] {SYNC, IDLE, LOW, HIGH} state_t;

  state_t                state, state_nxt;
  logic                  s1, s2, s_d;
  logic                  s, rise, fall;
  logic [LW-1:0]         low_cnt, low_nxt;
  logic [HW-1:0]         high_cnt, high_nxt;
  logic                  ev_bit, ev_err, ev_end, bit_val;
  logic [23:0]           shreg;
  logic [4:0]            bit_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  px_done, valid_pend;

  assign s    = s2;
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= led_data_i;
      s2  <= s1;
      s_d <= s2;
    end
  end

  // State and pulse-width counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= SYNC;
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      state    <= state_nxt;
      low_cnt  <= low_nxt;
      high_cnt <= high_nxt;
    end
  end

  // Next-state, counter update and bit/error/frame-end events.
  always_comb begin
    state_nxt = state;
    low_nxt   = low_cnt;
    high_nxt  = high_cnt;
    ev_bit    = 1'b0;
    ev_err    = 1'b0;
    ev_end    = 1'b0;
    bit_val   = (high_cnt >= HW'(T_THRESHOLD));
    case (state)
      SYNC: begin
        // Any high restarts the quiet-time measurement; edges never decode here.
        if (s) low_nxt = '0;
        else if (low_cnt != LW'(T_RESET)) low_nxt = low_cnt + LW'(1);
        if (low_cnt == LW'(T_RESET)) state_nxt = IDLE;
      end
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          high_nxt  = HW'(1);
        end else if (!s && low_cnt != LW'(T_RESET)) begin
          low_nxt = low_cnt + LW'(1);
        end
      end
      LOW: begin
        // Frame end wins; a coincident rise then opens the next frame.
        if (low_cnt == LW'(T_RESET)) begin
          ev_end    = 1'b1;
          state_nxt = IDLE;
        end
        if (rise) begin
          state_nxt = HIGH;
          high_nxt  = HW'(1);
        end else if (!s && low_cnt != LW'(T_RESET)) begin
          low_nxt = low_cnt + LW'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt = LOW;
          low_nxt   = LW'(1);
          if (high_cnt > HW'(T_HIGH_MAX)) ev_err = 1'b1;
          else                            ev_bit = 1'b1;
        end else if (s && high_cnt != HW'(T_HIGH_MAX + 1)) begin
          high_nxt = high_cnt + HW'(1);
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Bit assembly, pixel emission, address tracking and status strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg             <= '0;
      bit_cnt           <= '0;
      addr              <= '0;
      px_done           <= 1'b0;
      valid_pend        <= 1'b0;
      pix.pixel_g_o     <= '0;
      pix.pixel_r_o     <= '0;
      pix.pixel_b_o     <= '0;
      pix.led_address_o <= '0;
      pix.pixel_valid_o <= 1'b0;
      pix.frame_done_o  <= 1'b0;
      pix.bit_error_o   <= 1'b0;
      pix.overflow_o    <= 1'b0;
    end else begin
      px_done           <= 1'b0;
      valid_pend        <= 1'b0;
      pix.pixel_valid_o <= valid_pend;
      pix.frame_done_o  <= 1'b0;
      pix.bit_error_o   <= 1'b0;

      if (ev_bit) begin
        shreg <= {shreg[22:0], bit_val};
        if (bit_cnt == 5'd23) begin
          bit_cnt <= '0;
          px_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end

      if (ev_err) begin
        bit_cnt         <= '0;
        pix.bit_error_o <= 1'b1;
      end

      // Completed word is presented one cycle ahead of its strobe.
      if (px_done) begin
        if (addr == ADDR_WIDTH'(LED_COUNT)) begin
          pix.overflow_o <= 1'b1;
        end else begin
          pix.pixel_g_o     <= shreg[23:16];
          pix.pixel_r_o     <= shreg[15:8];
          pix.pixel_b_o     <= shreg[7:0];
          pix.led_address_o <= addr;
          addr              <= addr + ADDR_WIDTH'(1);
          valid_pend        <= 1'b1;
        end
      end

      if (ev_end) begin
        pix.frame_done_o <= 1'b1;
        pix.bit_error_o  <= (bit_cnt != 5'd0);
        pix.overflow_o   <= 1'b0;
        addr             <= '0;
        bit_cnt          <= '0;
      end
    end
  end

`ifdef WS2812_DECODER_FORWARD_EN
  logic forward_en, fwd_gate, fwd_gate_now;

  // Gate is only re-evaluated on a rise so a pulse is never cut or started mid-level.
  assign fwd_gate_now = rise ? forward_en : fwd_gate;

  // Repeat path: pass the stream once this LED's own pixel has been consumed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      forward_en <= 1'b0;
      fwd_gate   <= 1'b0;
      led_data_o <= 1'b0;
    end else begin
      if (ev_end)                       forward_en <= 1'b0;
      else if (px_done && addr == '0)   forward_en <= 1'b1;
      fwd_gate   <= fwd_gate_now;
      led_data_o <= s & fwd_gate_now;
    end
  end
`else
  assign led_data_o = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder: a per-pixel vector table plus hand
// sequences for latency, truncation, long pulse and mid-frame reset.
module tb_ws2812_decoder;

`ifdef WS2812_DECODER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led = 1'b0;
  logic fwd1, fwd2;

  ws2812_decoder_if #(.ADDR_WIDTH(10)) bus1 ();
  ws2812_decoder_if #(.ADDR_WIDTH(10)) bus2 ();

  ws2812_decoder dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .led_data_i(led), .led_data_o(fwd1), .pix(bus1)
  );

  ws2812_decoder #(.LED_COUNT(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .led_data_i(led), .led_data_o(fwd2), .pix(bus2)
  );

  always #10 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_done = 0, n_err = 0, n_err_done = 0, n_pix2 = 0, n_fwd = 0;
  logic        fwd_prev = 1'b0;
  logic [33:0] pix_q[$];

  // Event monitor for both instances.
  always @(negedge clk) begin
    if (bus1.pixel_valid_o)
      pix_q.push_back({bus1.led_address_o, bus1.pixel_g_o, bus1.pixel_r_o, bus1.pixel_b_o});
    if (bus1.frame_done_o) n_done++;
    if (bus1.bit_error_o) n_err++;
    if (bus1.frame_done_o && bus1.bit_error_o) n_err_done++;
    if (bus2.pixel_valid_o) n_pix2++;
    if (fwd1 && !fwd_prev) n_fwd++;
    fwd_prev = fwd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_level(input logic v, input int unsigned n);
    led = v;
    repeat (n) @(negedge clk);
  endtask

  // 50 MHz: 0 = 18 high / 44 low, 1 = 40 high / 22 low.
  task automatic send_bit(input logic b);
    send_level(1'b1, b ? 40 : 18);
    send_level(1'b0, b ? 22 : 44);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  function automatic logic [37:0] outs1();
    return {bus1.pixel_g_o, bus1.pixel_r_o, bus1.pixel_b_o, bus1.led_address_o,
            bus1.pixel_valid_o, bus1.frame_done_o, bus1.bit_error_o, bus1.overflow_o};
  endfunction

  typedef struct {
    logic [23:0] grb;
    logic [9:0]  addr;
    int unsigned gap;
    int unsigned done;
    int unsigned ovf;
    int unsigned pix2;
    int unsigned fwd;
  } vec_t;

  vec_t        vecs[6];
  int unsigned d0, e0, ed0, p0, f0, lat;
  logic [33:0] got;
  logic [23:0] w;

  initial begin
    //          grb         addr   gap   done ovf pix2 fwd
    vecs[0] = '{24'hA53C0F, 10'd0, 3000, 1,   0,  1,   0 };
    vecs[1] = '{24'h112233, 10'd0, 0,    0,   0,  1,   0 };
    vecs[2] = '{24'h445566, 10'd1, 0,    0,   0,  1,   24};
    vecs[3] = '{24'h778899, 10'd2, 3000, 1,   1,  0,   24};
    vecs[4] = '{24'hFFFFFF, 10'd0, 0,    0,   0,  1,   0 };
    vecs[5] = '{24'h000000, 10'd1, 3000, 1,   0,  1,   24};

    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", outs1(), '0);
    check("reset_fwd", fwd1, 1'b0);
    rst_n = 1'b1;
    send_level(1'b0, 3000);

    for (int unsigned i = 0; i < 6; i++) begin
      d0 = n_done; e0 = n_err; p0 = n_pix2; f0 = n_fwd;
      send_pixel(vecs[i].grb);
      #2;
      check("pixel_count", pix_q.size(), 1);
      got = (pix_q.size() > 0) ? pix_q.pop_front() : '1;
      pix_q.delete();
      check("pixel_grb", got[23:0], vecs[i].grb);
      check("pixel_addr", got[33:24], vecs[i].addr);
      check("ovf_mid", bus2.overflow_o, vecs[i].ovf);
      check("dut2_strobes", n_pix2 - p0, vecs[i].pix2);
      send_level(1'b0, vecs[i].gap);
      #2;
      check("frame_done", n_done - d0, vecs[i].done);
      check("no_bit_error", n_err - e0, 0);
      check("ovf_end", bus2.overflow_o, (vecs[i].done != 0) ? 0 : vecs[i].ovf);
      check("fwd_rises", n_fwd - f0, FWD ? vecs[i].fwd : 0);
    end

    // Strobe latency from the first edge sampling the final low.
    w = 24'h5A5A5B;
    for (int i = 23; i >= 1; i--) send_bit(w[i]);
    send_level(1'b1, 40);
    led = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (bus1.pixel_valid_o && lat == 0) lat = k;
    end
    check("latency_edges", lat, 5);
    got = (pix_q.size() > 0) ? pix_q.pop_front() : '1;
    pix_q.delete();
    check("latency_pixel", got, {10'd0, 24'h5A5A5B});
    d0 = n_done;
    send_level(1'b0, 3000);
    #2;
    check("latency_frame_done", n_done - d0, 1);

    // Truncated pixel: 10 bits then frame gap.
    d0 = n_done; e0 = n_err; ed0 = n_err_done;
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    send_level(1'b0, 3000);
    #2;
    check("trunc_no_pixel", pix_q.size(), 0);
    check("trunc_done", n_done - d0, 1);
    check("trunc_err", n_err - e0, 1);
    check("trunc_err_with_done", n_err_done - ed0, 1);

    // Over-long high at bit 5, then a full pixel re-aligned after it.
    d0 = n_done; e0 = n_err;
    for (int i = 0; i < 5; i++) send_bit(~i[0]);
    send_level(1'b1, 100);
    send_level(1'b0, 22);
    #2;
    check("long_high_err", n_err - e0, 1);
    check("long_high_no_pixel", pix_q.size(), 0);
    send_pixel(24'h123456);
    #2;
    got = (pix_q.size() > 0) ? pix_q.pop_front() : '1;
    check("realign_pixel", got, {10'd0, 24'h123456});
    send_level(1'b0, 3000);
    #2;
    check("realign_done", n_done - d0, 1);
    check("realign_err_total", n_err - e0, 1);
    check("realign_no_extra", pix_q.size(), 0);

    // Reset during pixel 1; rest of frame must be ignored.
    send_pixel(24'h010203);
    #2;
    got = (pix_q.size() > 0) ? pix_q.pop_front() : '1;
    check("pre_reset_pixel", got, {10'd0, 24'h010203});
    w = 24'hDEADBE;
    for (int i = 23; i >= 16; i--) send_bit(w[i]);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", outs1(), '0);
    check("reset_mid_fwd", fwd1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done; e0 = n_err;
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
    send_pixel(24'h777777);
    send_level(1'b0, 3000);
    #2;
    check("ignored_no_pixel", pix_q.size(), 0);
    check("ignored_no_done", n_done - d0, 0);
    check("ignored_no_err", n_err - e0, 0);
    send_pixel(24'hABCDEF);
    send_level(1'b0, 3000);
    #2;
    got = (pix_q.size() > 0) ? pix_q.pop_front() : '1;
    check("post_reset_pixel", got, {10'd0, 24'hABCDEF});
    check("post_reset_done", n_done - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
